rstgen_seq: RTL and testbench



---
 rtl/rstgen_seq.sv | 147 ++++++++++++++
 tb/tb_rstgen_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rstgen_seq.sv
// Multi-channel reset sequencer: sync, hold, then ordered per-channel release.
// Optional RSTGEN_SEQ_SW_RESET_EN adds per-channel software reset from RUN.
module rstgen_seq #(
   parameter int NumChannels     = 4,
   parameter int SyncRegs        = 4,
   parameter int MinAssertCycles = 16,
   parameter int StepCycles      = 8,
   parameter int CntWidth        = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   ext_rst_ni,
   input  logic                   rst_test_mode_ni,
   input  logic                   test_mode_i,
   input  logic [NumChannels-1:0] sw_rst_req_i,
   output logic [NumChannels-1:0] rst_no,
   output logic                   init_no,
   output logic                   busy_o
);

   localparam int MaxCnt = (MinAssertCycles > StepCycles) ?
                           MinAssertCycles : StepCycles;
   localparam int IdxW   = (NumChannels > 1) ? $clog2(NumChannels) : 1;

   localparam logic [CntWidth-1:0] MinLast  = CntWidth'(MinAssertCycles - 1);
   localparam logic [CntWidth-1:0] StepLast = CntWidth'(StepCycles - 1);
   localparam logic [IdxW-1:0]     IdxLast  = IdxW'(NumChannels - 1);

   if (NumChannels < 1) begin : g_chk_nch
      $fatal(1, "rstgen_seq: NumChannels must be >= 1");
   end
   if (SyncRegs < 2) begin : g_chk_sync
      $fatal(1, "rstgen_seq: SyncRegs must be >= 2");
   end
   if (MinAssertCycles < 1 || StepCycles < 1) begin : g_chk_cyc
      $fatal(1, "rstgen_seq: cycle counts must be >= 1");
   end
   if ((MaxCnt - 1) >= (2 ** CntWidth)) begin : g_chk_cnt
      $fatal(1, "rstgen_seq: CntWidth too small");
   end

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_RELEASE,
      ST_RUN
`ifdef RSTGEN_SEQ_SW_RESET_EN
      , ST_SW_ASSERT
`endif
   } state_e;

   logic [SyncRegs-1:0]    sync_q;
   logic                   s;
   state_e                 state_q;
   logic [CntWidth-1:0]    cnt_q;
   logic [IdxW-1:0]        idx_q;
   logic [NumChannels-1:0] released_q;

`ifdef RSTGEN_SEQ_SW_RESET_EN
   logic [NumChannels-1:0] mask_q;
`else
   logic unused_sw_req;
   assign unused_sw_req = ^sw_rst_req_i;
`endif

   assign s = sync_q[SyncRegs-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q     <= '0;
         state_q    <= ST_ASSERT;
         cnt_q      <= '0;
         idx_q      <= '0;
         released_q <= '0;
`ifdef RSTGEN_SEQ_SW_RESET_EN
         mask_q     <= '0;
`endif
      end else begin
         sync_q <= {sync_q[SyncRegs-2:0], ext_rst_ni};
         // A fresh request outranks any release scheduled on this edge.
         if (!s && state_q != ST_ASSERT) begin
            released_q <= '0;
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
         end else begin
            unique case (state_q)
               ST_ASSERT: begin
                  if (!s) begin
                     cnt_q <= '0;
                  end else if (cnt_q == MinLast) begin
                     state_q <= ST_RELEASE;
                     cnt_q   <= '0;
                     idx_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_RELEASE: begin
                  if (cnt_q == StepLast) begin
                     released_q[idx_q] <= 1'b1;
                     cnt_q             <= '0;
                     idx_q             <= idx_q + 1'b1;
                     if (idx_q == IdxLast) begin
                        state_q <= ST_RUN;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_RUN: begin
`ifdef RSTGEN_SEQ_SW_RESET_EN
                  if (sw_rst_req_i != '0) begin
                     mask_q     <= sw_rst_req_i;
                     released_q <= ~sw_rst_req_i;
                     state_q    <= ST_SW_ASSERT;
                     cnt_q      <= '0;
                  end
`else
                  state_q <= ST_RUN;
`endif
               end
`ifdef RSTGEN_SEQ_SW_RESET_EN
               ST_SW_ASSERT: begin
                  if (cnt_q == MinLast) begin
                     released_q <= released_q | mask_q;
                     state_q    <= ST_RUN;
                     cnt_q      <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
`endif
               default: begin
                  state_q <= ST_ASSERT;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end
            endcase
         end
      end
   end

   assign rst_no  = test_mode_i ? {NumChannels{rst_test_mode_ni}} : released_q;
   assign init_no = test_mode_i | (state_q == ST_RUN);
   assign busy_o  = (state_q != ST_RUN);

endmodule

// File: tb/tb_rstgen_seq.sv
// Randomized bench for rstgen_seq against a count-based behavioural model.
// Honours RSTGEN_SEQ_SW_RESET_EN the same way as the design.
module tb_rstgen_seq;

   localparam int N  = 4;
   localparam int SR = 2;
   localparam int MA = 4;
   localparam int ST = 3;
   localparam int CW = 8;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic         rst_i;
   logic         ext_rst_ni;
   logic         rst_test_mode_ni;
   logic         test_mode_i;
   logic [N-1:0] sw_rst_req_i;
   logic [N-1:0] rst_no;
   logic         init_no;
   logic         busy_o;

   rstgen_seq #(
      .NumChannels     (N),
      .SyncRegs        (SR),
      .MinAssertCycles (MA),
      .StepCycles      (ST),
      .CntWidth        (CW)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ext_rst_ni       (ext_rst_ni),
      .rst_test_mode_ni (rst_test_mode_ni),
      .test_mode_i      (test_mode_i),
      .sw_rst_req_i     (sw_rst_req_i),
      .rst_no           (rst_no),
      .init_no          (init_no),
      .busy_o           (busy_o)
   );

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   // Model: n = consecutive edges with synchronised request high.
   logic [SR-1:0] m_sync;
   int            m_n;
   int            m_swleft;
   logic [N-1:0]  m_mask;

   function automatic int rel_count(input int n);
      int r;
      if (n < MA) return 0;
      r = (n - MA) / ST;
      return (r > N) ? N : r;
   endfunction

   task automatic model_edge();
      logic s_old;
`ifdef RSTGEN_SEQ_SW_RESET_EN
      logic in_run;
`endif
      if (rst_i) begin
         m_sync   = '0;
         m_n      = 0;
         m_swleft = 0;
      end else begin
         s_old = m_sync[SR-1];
`ifdef RSTGEN_SEQ_SW_RESET_EN
         in_run = (rel_count(m_n) == N) && (m_swleft == 0);
`endif
         m_sync = {m_sync[SR-2:0], ext_rst_ni};
         if (!s_old) begin
            m_n      = 0;
            m_swleft = 0;
         end else begin
`ifdef RSTGEN_SEQ_SW_RESET_EN
            if (m_swleft > 0) begin
               m_swleft--;
            end else if (in_run && sw_rst_req_i != '0) begin
               m_swleft = MA;
               m_mask   = sw_rst_req_i;
            end
`endif
            if (m_n < 100000) m_n++;
         end
      end
   endtask

   task automatic model_check();
      int           rel;
      logic [N-1:0] exp_rst;
      logic         run;
      rel     = rel_count(m_n);
      exp_rst = N'((1 << rel) - 1);
      if (m_swleft > 0) exp_rst = exp_rst & ~m_mask;
      run = (rel == N) && (m_swleft == 0);
      if (test_mode_i) exp_rst = {N{rst_test_mode_ni}};
      chk("rst_no", 32'(rst_no), 32'(exp_rst));
      chk("init_no", 32'(init_no), 32'(test_mode_i | run));
      chk("busy_o", 32'(busy_o), 32'(!run));
   endtask

   task automatic cycle(input logic r, input logic e, input logic rtm,
                        input logic tm, input logic [N-1:0] sw);
      rst_i            = r;
      ext_rst_ni       = e;
      rst_test_mode_ni = rtm;
      test_mode_i      = tm;
      sw_rst_req_i     = sw;
      @(posedge clk_i);
      model_edge();
      #1;
      model_check();
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
   endtask

   int rise [N];
   int lowcnt;
   int guard;

   initial begin
      m_sync   = '0;
      m_n      = 0;
      m_swleft = 0;
      m_mask   = '0;

      // Power-on with absolute release edges.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
      for (int b = 0; b < N; b++) rise[b] = 0;
      for (int e = 1; e <= 20; e++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
         for (int b = 0; b < N; b++)
            if (rst_no[b] && rise[b] == 0) rise[b] = e;
         if (e == 17) chk("init_before18", 32'(init_no), 32'd0);
         if (e == 18) begin
            chk("init_at18", 32'(init_no), 32'd1);
            chk("busy_at18", 32'(busy_o), 32'd0);
         end
      end
      for (int b = 0; b < N; b++)
         chk($sformatf("rise%0d", b), 32'(rise[b]), 32'(9 + 3 * b));

      // Re-reset right after channel 1 is released.
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
      guard = 0;
      while (rel_count(m_n) < 2 && guard < 100) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
         guard++;
      end
      chk("rerst_reach", 32'(guard < 100), 32'd1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
      idle(30);

      // Glitch filter: short high windows never release anything.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 2 + k; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
         for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
      end
      idle(25);

      // Test mode across a full sequence.
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 24; i++) cycle(1'b0, 1'b1, 1'(i), 1'b1, '0);
      idle(5);

      // Block reset while running.
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
      idle(25);

      // Software reset pulse on channel 2.
      lowcnt = 0;
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'b0100);
      if (rst_no == 4'b1011) lowcnt++;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
         if (rst_no == 4'b1011) lowcnt++;
      end
`ifdef RSTGEN_SEQ_SW_RESET_EN
      chk("sw_window", 32'(lowcnt), 32'd4);
`else
      chk("sw_window", 32'(lowcnt), 32'd0);
`endif
      chk("sw_after", 32'(rst_no), 32'hf);

      // Random segments.
      for (int seg = 0; seg < 120; seg++) begin
         int hi;
         int lo;
         hi = $urandom_range(1, 40);
         lo = $urandom_range(1, 5);
         for (int i = 0; i < hi + lo; i++) begin
            logic [N-1:0] sw;
            sw = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 15)) : '0;
            cycle(1'($urandom_range(0, 199) == 0), 1'(i < hi),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                  sw);
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
